// File: rtl/lane_valu.sv
// lane_valu: per-lane vector integer ALU. Consumes paired ALUA/ALUB operand
// words, computes element-wise results at the instruction's SEW and returns
// them as VRF write requests through a one-entry output register.
// Optional feature: define LANE_VALU_MINMAX_EN to build the signed MIN/MAX
// comparators; without it opcodes 5/6 produce zero data like opcode 7.
module lane_valu #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned IdWidth   = 2,
   parameter int unsigned VlWidth   = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [2:0]             req_op_i,
   input  logic [1:0]             req_sew_i,
   input  logic [AddrWidth-1:0]   req_vd_i,
   input  logic [VlWidth-1:0]     req_vlB_i,
   input  logic [IdWidth-1:0]     req_id_i,
   input  logic                   opa_valid_i,
   output logic                   opa_ready_o,
   input  logic [DataWidth-1:0]   opa_i,
   input  logic                   opb_valid_i,
   output logic                   opb_ready_o,
   input  logic [DataWidth-1:0]   opb_i,
   output logic                   result_valid_o,
   input  logic                   result_gnt_i,
   output logic [DataWidth-1:0]   result_wdata_o,
   output logic [DataWidth/8-1:0] result_wstrb_o,
   output logic [AddrWidth-1:0]   result_addr_o,
   output logic [IdWidth-1:0]     result_id_o,
   output logic                   done_o,
   output logic [IdWidth-1:0]     done_id_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned NumChunks = DataWidth / 64;
   localparam logic [VlWidth-1:0] WordBytes = VlWidth'(StrbWidth);

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
`ifdef LANE_VALU_MINMAX_EN
   localparam logic [2:0] OpMin = 3'd5;
   localparam logic [2:0] OpMax = 3'd6;
`endif

   typedef enum logic [1:0] {IDLE, EXEC, DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [2:0]             op_q;
   logic [1:0]             sew_q;
   logic [IdWidth-1:0]     id_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [VlWidth-1:0]     rem_q;
   logic                   accept;
   logic                   fire;
   logic                   last_word;
   logic [StrbWidth-1:0]   strb_d;

   logic                   vld_p1;
   logic [DataWidth-1:0]   wdata_p1;
   logic [StrbWidth-1:0]   wstrb_p1;
   logic [AddrWidth-1:0]   addr_p1;
   logic [IdWidth-1:0]     id_p1;

   // Remaining byte count after one word, floored at zero.
   function automatic logic [VlWidth-1:0] sat_sub_word(input logic [VlWidth-1:0] rem);
      sat_sub_word = (rem > WordBytes) ? (rem - WordBytes) : '0;
   endfunction

   // One element operation on sign-extended operands; the caller keeps only
   // the element's low bits, so carries never leak into a neighbour.
   function automatic logic [63:0] alu_elem(input logic [2:0] op,
                                            input logic signed [63:0] a,
                                            input logic signed [63:0] b);
      logic [63:0] r;
      r = '0;
      case (op)
         OpAdd:   r = a + b;
         OpSub:   r = a - b;
         OpAnd:   r = a & b;
         OpOr:    r = a | b;
         OpXor:   r = a ^ b;
`ifdef LANE_VALU_MINMAX_EN
         OpMin:   r = (a < b) ? a : b;
         OpMax:   r = (a < b) ? b : a;
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // Full-word result: every 64-bit chunk is split into SEW-sized elements.
   function automatic logic [DataWidth-1:0] alu_word(input logic [2:0]           op,
                                                     input logic [1:0]           sew,
                                                     input logic [DataWidth-1:0] a,
                                                     input logic [DataWidth-1:0] b);
      logic [DataWidth-1:0] r;
      logic [63:0]          ca, cb, rc, er;
      r = '0;
      for (int c = 0; c < NumChunks; c++) begin
         ca = a[c*64 +: 64];
         cb = b[c*64 +: 64];
         rc = '0;
         case (sew)
            2'd0: for (int e = 0; e < 8; e++) begin
               er = alu_elem(op, {{56{ca[e*8+7]}}, ca[e*8 +: 8]},
                                 {{56{cb[e*8+7]}}, cb[e*8 +: 8]});
               rc[e*8 +: 8] = er[7:0];
            end
            2'd1: for (int e = 0; e < 4; e++) begin
               er = alu_elem(op, {{48{ca[e*16+15]}}, ca[e*16 +: 16]},
                                 {{48{cb[e*16+15]}}, cb[e*16 +: 16]});
               rc[e*16 +: 16] = er[15:0];
            end
            2'd2: for (int e = 0; e < 2; e++) begin
               er = alu_elem(op, {{32{ca[e*32+31]}}, ca[e*32 +: 32]},
                                 {{32{cb[e*32+31]}}, cb[e*32 +: 32]});
               rc[e*32 +: 32] = er[31:0];
            end
            default: rc = alu_elem(op, ca, cb);
         endcase
         r[c*64 +: 64] = rc;
      end
      return r;
   endfunction

   assign last_word = (rem_q <= WordBytes);

   // Byte strobes for the word being produced: low rem_q bytes, capped at a full word.
   always_comb begin
      strb_d = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         strb_d[i] = (rem_q > VlWidth'(i));
      end
   end

   // Next-state and handshake decode; DRAIN retires once the output register is empty.
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      done_o      = 1'b0;
      accept      = 1'b0;
      fire        = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            accept      = req_valid_i;
            if (accept) begin
               state_d = (req_vlB_i == '0) ? DRAIN : EXEC;
            end
         end
         EXEC: begin
            fire = opa_valid_i && opb_valid_i && (!vld_p1 || result_gnt_i);
            if (fire && last_word) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!vld_p1) begin
               done_o      = 1'b1;
               req_ready_o = 1'b1;
               accept      = req_valid_i;
               if (accept) begin
                  state_d = (req_vlB_i == '0) ? DRAIN : EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus per-instruction context (address and remaining bytes advance per fire).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         op_q    <= '0;
         sew_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= req_op_i;
            sew_q  <= req_sew_i;
            id_q   <= req_id_i;
            addr_q <= req_vd_i;
            rem_q  <= req_vlB_i;
         end else if (fire) begin
            addr_q <= addr_q + AddrWidth'(1);
            rem_q  <= sat_sub_word(rem_q);
         end
      end
   end

   // ---- stage p0 (operand fire) -> stage p1 (write request register) ----
   // Output register: reload on fire, otherwise empty out on grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1   <= 1'b0;
         wdata_p1 <= '0;
         wstrb_p1 <= '0;
         addr_p1  <= '0;
         id_p1    <= '0;
      end else if (fire) begin
         vld_p1   <= 1'b1;
         wdata_p1 <= alu_word(op_q, sew_q, opa_i, opb_i);
         wstrb_p1 <= strb_d;
         addr_p1  <= addr_q;
         id_p1    <= id_q;
      end else if (result_gnt_i) begin
         vld_p1   <= 1'b0;
         wdata_p1 <= '0;
         wstrb_p1 <= '0;
         addr_p1  <= '0;
         id_p1    <= '0;
      end
   end

   assign opa_ready_o    = fire;
   assign opb_ready_o    = fire;
   assign result_valid_o = vld_p1;
   assign result_wdata_o = wdata_p1;
   assign result_wstrb_o = wstrb_p1;
   assign result_addr_o  = addr_p1;
   assign result_id_o    = id_p1;
   assign done_id_o      = id_q;

endmodule

// File: tb/tb_lane_valu.sv
// Self-checking bench for lane_valu: expected write requests are queued when
// an instruction is issued and compared as the DUT's requests are granted.
module tb_lane_valu;

   logic        clk;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_op_i;
   logic [1:0]  req_sew_i;
   logic [9:0]  req_vd_i;
   logic [11:0] req_vlB_i;
   logic [1:0]  req_id_i;
   logic        opa_valid_i, opa_ready_o;
   logic [63:0] opa_i;
   logic        opb_valid_i, opb_ready_o;
   logic [63:0] opb_i;
   logic        result_valid_o;
   logic        result_gnt_i;
   logic [63:0] result_wdata_o;
   logic [7:0]  result_wstrb_o;
   logic [9:0]  result_addr_o;
   logic [1:0]  result_id_o;
   logic        done_o;
   logic [1:0]  done_id_o;

   typedef struct packed {
      logic [9:0]  addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [1:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_gnt_cyc = 0;

   lane_valu #(
      .DataWidth(64),
      .AddrWidth(10),
      .IdWidth(2),
      .VlWidth(12)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op_i),
      .req_sew_i     (req_sew_i),
      .req_vd_i      (req_vd_i),
      .req_vlB_i     (req_vlB_i),
      .req_id_i      (req_id_i),
      .opa_valid_i   (opa_valid_i),
      .opa_ready_o   (opa_ready_o),
      .opa_i         (opa_i),
      .opb_valid_i   (opb_valid_i),
      .opb_ready_o   (opb_ready_o),
      .opb_i         (opb_i),
      .result_valid_o(result_valid_o),
      .result_gnt_i  (result_gnt_i),
      .result_wdata_o(result_wdata_o),
      .result_wstrb_o(result_wstrb_o),
      .result_addr_o (result_addr_o),
      .result_id_o   (result_id_o),
      .done_o        (done_o),
      .done_id_o     (done_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference element-wise result, built from shifts and arithmetic right shift.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [1:0] sew,
                                         input logic [63:0] a, input logic [63:0] b);
      int          w;
      logic [63:0] r, mask;
      longint      sa, sb, sr;
      w    = 8 << sew;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      r    = '0;
      for (int i = 0; i < 64 / w; i++) begin
         sa = $signed((a >> (i * w)) << (64 - w)) >>> (64 - w);
         sb = $signed((b >> (i * w)) << (64 - w)) >>> (64 - w);
         case (op)
            3'd0: sr = sa + sb;
            3'd1: sr = sa - sb;
            3'd2: sr = sa & sb;
            3'd3: sr = sa | sb;
            3'd4: sr = sa ^ sb;
`ifdef LANE_VALU_MINMAX_EN
            3'd5: sr = (sa < sb) ? sa : sb;
            3'd6: sr = (sa < sb) ? sb : sa;
`endif
            default: sr = 0;
         endcase
         r = r | ((64'(sr) & mask) << (i * w));
      end
      return r;
   endfunction

   task automatic push_exp(input logic [2:0] op, input logic [1:0] sew, input logic [9:0] vd,
                           input logic [11:0] vlb, input logic [1:0] id,
                           input logic [63:0] a, input logic [63:0] b);
      int         rem;
      logic [9:0] addr;
      exp_t       e;
      rem  = int'(vlb);
      addr = vd;
      while (rem > 0) begin
         e.addr = addr;
         e.data = model(op, sew, a, b);
         e.strb = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
         e.id   = id;
         exp_q.push_back(e);
         addr = addr + 10'd1;
         rem  = (rem > 8) ? rem - 8 : 0;
      end
   endtask

   // Scoreboard: every granted write request must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_ni && result_valid_o && result_gnt_i) begin
         check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(result_addr_o), 64'(e.addr));
            check("wr_data", result_wdata_o, e.data);
            check("wr_strb", 64'(result_wstrb_o), 64'(e.strb));
            check("wr_id", 64'(result_id_o), 64'(e.id));
            last_gnt_cyc = cyc;
         end
      end
   end

   // Called at posedge+1; returns the cycle in which the handshake was seen.
   task automatic issue(input logic [2:0] op, input logic [1:0] sew, input logic [9:0] vd,
                        input logic [11:0] vlb, input logic [1:0] id, output int hs);
      logic ok;
      ok          = 1'b0;
      hs          = 0;
      req_op_i    = op;
      req_sew_i   = sew;
      req_vd_i    = vd;
      req_vlB_i   = vlb;
      req_id_i    = id;
      req_valid_i = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (req_ready_o) begin
            ok = 1'b1;
            hs = cyc;
         end
      end
      check("req_accepted", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done(output int dc, output logic [1:0] did);
      logic ok;
      ok  = 1'b0;
      dc  = 0;
      did = '0;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (done_o) begin
            ok  = 1'b1;
            dc  = cyc;
            did = done_id_o;
         end
      end
      check("done_seen", 64'(ok), 64'd1);
   endtask

   // Wait for retirement, check done id/timing, and return at posedge+1.
   task automatic finish_instr(input logic [11:0] vlb, input logic [1:0] id, input int hs);
      int         dc;
      logic [1:0] did;
      wait_done(dc, did);
      opa_valid_i = 1'b0;
      opb_valid_i = 1'b0;
      check("done_id", 64'(did), 64'(id));
      if (vlb == 12'd0) check("done_zero_len_cycle", 64'(dc), 64'(hs + 1));
      else              check("done_after_last_gnt", 64'(dc), 64'(last_gnt_cyc + 1));
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [1:0] sew, input logic [9:0] vd,
                            input logic [11:0] vlb, input logic [1:0] id,
                            input logic [63:0] a, input logic [63:0] b, output int hs);
      push_exp(op, sew, vd, vlb, id, a, b);
      issue(op, sew, vd, vlb, id, hs);
      opa_i       = a;
      opb_i       = b;
      opa_valid_i = 1'b1;
      opb_valid_i = 1'b1;
      finish_instr(vlb, id, hs);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
      check({tag, "_opa_ready"}, 64'(opa_ready_o), 64'd0);
      check({tag, "_opb_ready"}, 64'(opb_ready_o), 64'd0);
      check({tag, "_res_valid"}, 64'(result_valid_o), 64'd0);
      check({tag, "_done"}, 64'(done_o), 64'd0);
      check({tag, "_wdata"}, result_wdata_o, 64'd0);
      check({tag, "_wstrb"}, 64'(result_wstrb_o), 64'd0);
      check({tag, "_addr"}, 64'(result_addr_o), 64'd0);
      check({tag, "_id"}, 64'(result_id_o), 64'd0);
      check({tag, "_done_id"}, 64'(done_id_o), 64'd0);
   endtask

   initial begin
      int          hs, rel;
      logic        ok;
      logic [63:0] a, b, w0;

      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      req_op_i     = '0;
      req_sew_i    = '0;
      req_vd_i     = '0;
      req_vlB_i    = '0;
      req_id_i     = '0;
      opa_valid_i  = 1'b0;
      opb_valid_i  = 1'b0;
      opa_i        = '0;
      opb_i        = '0;
      result_gnt_i = 1'b1;
      #3;
      check_reset("rst0");
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // ADD e8: 0x01 + 0xFF wraps to zero in every byte, no carry between bytes.
      run_instr(3'd0, 2'd0, 10'h010, 12'd16, 2'd1,
                64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF, hs);

      // SUB e32 with partial second word.
      run_instr(3'd1, 2'd2, 10'h050, 12'd12, 2'd2,
                64'h0000_0001_0000_0000, 64'h0000_0002_0000_0001, hs);
      check("sub_model_word0", model(3'd1, 2'd2, 64'h0000_0001_0000_0000,
                                     64'h0000_0002_0000_0001), 64'hFFFF_FFFF_FFFF_FFFF);

      // Grant withheld: operands stay unconsumed and the payload is frozen.
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      w0 = model(3'd0, 2'd1, a, b);
      result_gnt_i = 1'b0;
      push_exp(3'd0, 2'd1, 10'h020, 12'd32, 2'd3, a, b);
      issue(3'd0, 2'd1, 10'h020, 12'd32, 2'd3, hs);
      opa_i = a;
      opb_i = b;
      opa_valid_i = 1'b1;
      opb_valid_i = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = result_valid_o;
      end
      check("stall_first_valid", 64'(ok), 64'd1);
      check("stall_first_latency", 64'(cyc), 64'(hs + 2));
      for (int k = 0; k < 5; k++) begin
         check("stall_opa_ready", 64'(opa_ready_o), 64'd0);
         check("stall_opb_ready", 64'(opb_ready_o), 64'd0);
         check("stall_valid", 64'(result_valid_o), 64'd1);
         check("stall_wdata", result_wdata_o, w0);
         check("stall_addr", 64'(result_addr_o), 64'h020);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      result_gnt_i = 1'b1;
      @(negedge clk);
      check("stall_release_fire", 64'(opa_ready_o), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("stall_next_valid", 64'(result_valid_o), 64'd1);
      check("stall_next_addr", 64'(result_addr_o), 64'h021);
      finish_instr(12'd32, 2'd3, hs);

      // Only one operand stream valid: nothing is consumed.
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      push_exp(3'd0, 2'd3, 10'h030, 12'd8, 2'd2, a, b);
      issue(3'd0, 2'd3, 10'h030, 12'd8, 2'd2, hs);
      opa_i = a;
      opb_i = b;
      opa_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("half_opa_ready", 64'(opa_ready_o), 64'd0);
         check("half_opb_ready", 64'(opb_ready_o), 64'd0);
         check("half_res_valid", 64'(result_valid_o), 64'd0);
      end
      @(posedge clk);
      #1;
      opb_valid_i = 1'b1;
      finish_instr(12'd8, 2'd2, hs);

      // Zero-length instruction: done the cycle after acceptance, no write.
      run_instr(3'd0, 2'd0, 10'h070, 12'd0, 2'd1, 64'd5, 64'd6, hs);

      // Address wrap at the top of the VRF.
      run_instr(3'd4, 2'd1, 10'h3FF, 12'd13, 2'd0,
                {$urandom, $urandom}, {$urandom, $urandom}, hs);

      // Every opcode at assorted SEW and lengths.
      for (int k = 0; k < 16; k++) begin
         run_instr(3'(k % 8), 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
                   12'($urandom_range(1, 30)), 2'(k % 4),
                   {$urandom, $urandom}, {$urandom, $urandom}, hs);
      end

      // Reset while the first of four words is held in the output register.
      result_gnt_i = 1'b0;
      issue(3'd0, 2'd0, 10'h040, 12'd32, 2'd2, hs);
      opa_i = 64'h1111_1111_1111_1111;
      opb_i = 64'h2222_2222_2222_2222;
      opa_valid_i = 1'b1;
      opb_valid_i = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = result_valid_o;
      end
      check("rst_mid_valid", 64'(ok), 64'd1);
      check("rst_mid_wdata", result_wdata_o, 64'h3333_3333_3333_3333);
      @(posedge clk);
      #2;
      rst_ni = 1'b0;
      opa_valid_i = 1'b0;
      opb_valid_i = 1'b0;
      #1;
      check_reset("rst_mid");
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      result_gnt_i = 1'b1;
      rel = cyc;
      run_instr(3'd0, 2'd2, 10'h060, 12'd8, 2'd3,
                64'h0000_0005_FFFF_FFFF, 64'h0000_0003_0000_0001, hs);
      check("rst_accept_immediate", 64'(hs), 64'(rel));

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
